// File: rtl/alu_divider_pkg.sv
// Shared ALU control constants and divider state encoding.
package alu_divider_pkg;

  localparam logic [4:0] OPADD  = 5'd0;
  localparam logic [4:0] OPSUB  = 5'd1;
  localparam logic [4:0] OPSLL  = 5'd2;
  localparam logic [4:0] OPSLT  = 5'd3;
  localparam logic [4:0] OPSLTU = 5'd4;
  localparam logic [4:0] OPXOR  = 5'd5;
  localparam logic [4:0] OPSRL  = 5'd6;
  localparam logic [4:0] OPSRA  = 5'd7;
  localparam logic [4:0] OPOR   = 5'd8;
  localparam logic [4:0] OPAND  = 5'd9;
  localparam logic [4:0] OPMUL  = 5'd10;
  localparam logic [4:0] OPMULH = 5'd11;
  localparam logic [4:0] OPDIV  = 5'd12;
  localparam logic [4:0] OPDIVU = 5'd13;
  localparam logic [4:0] OPREM  = 5'd14;
  localparam logic [4:0] OPREMU = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_e;

  function automatic logic isDivOp(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
  endfunction

  function automatic logic isSignedOp(input logic [4:0] op);
    return (op == OPDIV) || (op == OPREM);
  endfunction

  function automatic logic isQuotientOp(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU);
  endfunction

endpackage

// File: rtl/alu_divider_if.sv
// Request/response bundle between the ALU control path and the divider.
interface alu_divider_if #(
  parameter int WIDTH = 64
);
  logic             iStart;
  logic [4:0]       iALUControl;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oResult;
  logic             oDivZero;

  modport master (
    output iStart, iALUControl, iA, iB,
    input  oBusy, oDone, oResult, oDivZero
  );

  modport slave (
    input  iStart, iALUControl, iA, iB,
    output oBusy, oDone, oResult, oDivZero
  );
endinterface

// File: rtl/alu_divider_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module alu_divider_div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] shiftedRem;
  logic [WIDTH:0] trialDiff;
  logic           noBorrow;

  // Shift the next dividend bit in, trial-subtract, restore on borrow.
  // When the bit shifted out of rem is set the partial remainder already
  // exceeds any WIDTH-bit divisor, so that case never borrows.
  always_comb begin
    shiftedRem = {rem, quo[WIDTH-1]};
    trialDiff  = shiftedRem - {1'b0, divisor};
    noBorrow   = shiftedRem[WIDTH] | ~trialDiff[WIDTH];
    remNext    = noBorrow ? trialDiff[WIDTH-1:0] : shiftedRem[WIDTH-1:0];
    quoNext    = {quo[WIDTH-2:0], noBorrow};
  end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle signed/unsigned divide and remainder, one quotient bit per cycle.
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  alu_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  divState_e        state, nextState;
  logic [4:0]       opReg;
  logic             negQuo, negRem;
  logic [WIDTH-1:0] remReg, quoReg, divisorReg, resultReg;
  logic [CNT_W-1:0] count;
  logic             divZeroReg;

  logic             accept, opSigned, bZero;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH-1:0] stepRem, stepQuo, finalResult;

  alu_divider_div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (remReg),
    .quo     (quoReg),
    .divisor (divisorReg),
    .remNext (stepRem),
    .quoNext (stepQuo)
  );

  // Request decode and magnitude conversion of the incoming operands.
  always_comb begin
    accept   = (state == IDLE) && bus.iStart && isDivOp(bus.iALUControl);
    opSigned = isSignedOp(bus.iALUControl);
    bZero    = (bus.iB == '0);
    absA     = (opSigned && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
    absB     = (opSigned && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
  end

  // Sign fix-up of the final step's quotient or remainder.
  always_comb begin
    if (isQuotientOp(opReg)) finalResult = negQuo ? -stepQuo : stepQuo;
    else                     finalResult = negRem ? -stepRem : stepRem;
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = bZero ? DONE : RUN;
      RUN:     if (count == CNT_W'(1)) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs depend only on registered state.
  always_comb begin
    bus.oBusy    = (state != IDLE);
    bus.oDone    = (state == DONE);
    bus.oResult  = resultReg;
    bus.oDivZero = divZeroReg;
  end

  // Operand capture, iteration and result load.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      opReg      <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      count      <= '0;
      resultReg  <= '0;
      divZeroReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opReg      <= bus.iALUControl;
            negQuo     <= opSigned && (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
            negRem     <= opSigned && bus.iA[WIDTH-1];
            remReg     <= '0;
            quoReg     <= absA;
            divisorReg <= absB;
            count      <= CNT_W'(WIDTH);
            if (bZero) begin
              resultReg  <= isQuotientOp(bus.iALUControl) ? '0 : bus.iA;
              divZeroReg <= 1'b1;
            end
          end
        end
        RUN: begin
          remReg <= stepRem;
          quoReg <= stepQuo;
          count  <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            resultReg  <= finalResult;
            divZeroReg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_divider.md
# alu_divider

Multi-cycle integer divide/remainder unit on the execute side of the ALU control interface. It accepts the 5-bit ALU operation code produced by the ALU control decoder together with two register operands. It executes OPDIV, OPDIVU, OPREM and OPREMU with a radix-2 restoring algorithm, one quotient bit per cycle. The control path holds the pipeline while oBusy is high and captures oResult when oDone pulses.

## Interface

- WIDTH, 64, operand and result width in bits; must be a power of two, minimum 8.
- iCLK  input  1  clock; all state changes on the rising edge.
- iRST_N  input  1  reset; asynchronous, active-low.
- iStart  input  1  request; sampled only in IDLE.
- iALUControl  input  5  operation code: OPDIV, OPDIVU, OPREM or OPREMU; all other codes are ignored.
- iA  input  WIDTH  dividend (rn).
- iB  input  WIDTH  divisor (rm).
- oBusy  output  1  high from the cycle after an accepted start until the cycle oDone is asserted, inclusive.
- oDone  output  1  one-cycle pulse; oResult and oDivZero are valid in this cycle.
- oResult  output  WIDTH  quotient or remainder; holds its value until the next accepted start.
- oDivZero  output  1  the last operation had iB == 0; held like oResult.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - iStart=1 with a supported code latches the op, iA and iB.
  - iB==0 goes to DONE; otherwise goes to RUN with the step counter at WIDTH.
  - iStart with an unsupported code is ignored and the block stays in IDLE.
- Signed ops (OPDIV, OPREM):
  - Operands are converted to magnitude before the iteration.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops (OPDIVU, OPREMU): operands are used as-is.
- RUN step, each cycle:
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - Trial subtract rem − divisor computed at WIDTH+1 bits.
  - If no borrow, keep the difference and set the quotient LSB to 1; else keep rem and set the LSB to 0.
  - Decrement the counter; at 0 go to DONE.
- DONE:
  - Drive oDone=1 and load oResult: quotient for DIV/DIVU, remainder for REM/REMU, with sign fix-up.
  - Next state is IDLE unconditionally.
  - iStart in DONE is ignored.
- Divide by zero: quotient = 0; remainder = iA unmodified; oDivZero=1. The result appears in the cycle after start.
- Signed overflow, most-negative / −1: quotient = most-negative value, remainder = 0, oDivZero=0. This falls out of the magnitude algorithm with no special case.
- iStart while oBusy=1 is ignored; the in-flight operation is not disturbed.
- Reset asserted at any time, including mid-RUN: abort immediately to IDLE. oBusy, oDone, oDivZero and oResult go to 0, and the counter and internal registers go to 0.

## Timing

- The start is accepted at edge k.
- Normal op:
  - oBusy is high over cycles k+1 … k+WIDTH+1.
  - oDone is high in cycle k+WIDTH+1.
  - Latency is WIDTH+1 cycles; 65 cycles for WIDTH=64.
- Divide by zero:
  - oBusy and oDone are both high in cycle k+1 only.
  - Latency is 1 cycle.
- Back-to-back: the earliest next accepted start is the edge that leaves DONE for IDLE, i.e. at the end of the oDone cycle the block is in IDLE. The next start is sampled in the following cycle.
- oResult only changes on the edge entering DONE, or on reset.
- Throughput: one operation per WIDTH+2 cycles.
- No combinational path from any input to any output.

## Structure

- OPDIV, OPDIVU, OPREM and OPREMU codes come from the shared parameter file used by the ALU control decoder, not redefined locally.
- The state encoding (IDLE, RUN, DONE) belongs in the same shared file, alongside the opcode constants.
- One natural sub-module: div_step. It is purely combinational: it takes rem, quo and divisor and returns the next rem and quo. Instantiated once; reusable for a later radix-4 version.
- The counter width is $clog2(WIDTH)+1.

## Test plan

- Reset mid-RUN: start OPDIVU 100/7, assert iRST_N=0 at cycle k+20 → all outputs 0 asynchronously. After release, the block is in IDLE and the next start of OPDIVU 100/7 yields oResult=14 after 65 cycles.
- Signed sign rules, one at a time:
  - OPDIV −7/2 → oResult=−3.
  - OPREM −7/2 → oResult=−1.
  - OPREM 7/−2 → oResult=1.
  - All with oDone at k+65.
- Divide by zero:
  - OPDIVU 5/0 → oResult=0, oDivZero=1, oDone at k+1.
  - OPREMU 5/0 → oResult=5.
- Overflow: OPDIV 0x8000_0000_0000_0000 / −1 → oResult=0x8000_0000_0000_0000; OPREM of the same → 0; oDivZero=0.
- Unsigned full range: OPDIVU 0xFFFF_FFFF_FFFF_FFFF/3 → 0x5555_5555_5555_5555; OPREMU of the same → 0.
- Handshake:
  - iStart held high through RUN with different operands → the first result is unchanged.
  - Unsupported code (OPADD) with iStart → oBusy stays 0.
  - Back-to-back ops → the second oDone is exactly 66 cycles after the first.
